// File: rtl/move_validator_board.sv
// Tic-tac-toe move validator for an N x N board: one move per handshake, legality checks,
// a line-by-line win scan, and draw detection once every cell is filled.
module move_validator_board #(
    parameter int BOARD_N = 3,
    parameter int POS_W   = $clog2(BOARD_N * BOARD_N)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           move_valid,
    output logic                           move_ready,
    input  logic                           player_id,
    input  logic [POS_W-1:0]               position,
    output logic                           result_valid,
    output logic [1:0]                     result_code,
    output logic                           turn,
    output logic                           game_over,
    output logic [1:0]                     winner,
    output logic [2*BOARD_N*BOARD_N-1:0]   board_flat
);

    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int LINES  = 2 * BOARD_N + 2;
    localparam int LINE_W = $clog2(LINES);
    localparam int CNT_W  = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        SCAN   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [POS_W-1:0]       pos_r;
    logic                   mover_r;
    logic [2*CELLS-1:0]     board_r;
    logic                   turn_r;
    logic [CNT_W-1:0]       count_r;
    logic                   over_r;
    logic [1:0]             winner_r;
    logic                   result_valid_r;
    logic [1:0]             result_code_r;
    logic [LINE_W-1:0]      line_r;
    logic                   hit_r;

    logic                   handshake_s;
    logic                   reject_s;
    logic [1:0]             code_s;
    int                     pos_idx_s;
    int                     cell_s;
    logic                   line_hit_s;
    logic [1:0]             mover_code_s;
    logic                   last_line_s;

    // Cell index of the i-th cell on the given scan line: rows, then columns, then both diagonals.
    function automatic int line_cell(input int line, input int i);
        if (line < BOARD_N) begin
            return line * BOARD_N + i;
        end else if (line < 2 * BOARD_N) begin
            return i * BOARD_N + (line - BOARD_N);
        end else if (line == 2 * BOARD_N) begin
            return i * BOARD_N + i;
        end else begin
            return i * BOARD_N + (BOARD_N - 1 - i);
        end
    endfunction

    assign handshake_s  = move_valid && move_ready;
    assign mover_code_s = {mover_r, ~mover_r};
    assign last_line_s  = (line_r == LINE_W'(LINES - 1));

    // Legality of the latched move, in priority order range / turn / occupancy.
    always_comb begin
        reject_s  = 1'b1;
        code_s    = 2'b00;
        pos_idx_s = 0;
        if (int'(pos_r) < CELLS) begin
            pos_idx_s = int'(pos_r);
        end else begin
            pos_idx_s = 0;
        end
        if (int'(pos_r) >= CELLS) begin
            code_s = 2'b10;
        end else if (mover_r != turn_r) begin
            code_s = 2'b11;
        end else if (board_r[2*pos_idx_s +: 2] != 2'b00) begin
            code_s = 2'b01;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Does every cell on the current scan line hold the mover's mark.
    always_comb begin
        line_hit_s = 1'b1;
        cell_s     = 0;
        for (int i = 0; i < BOARD_N; i++) begin
            cell_s = line_cell(int'(line_r), i);
            if (board_r[2*cell_s +: 2] != mover_code_s) begin
                line_hit_s = 1'b0;
            end else begin
                line_hit_s = line_hit_s;
            end
        end
    end

    // FSM state register; clear forces IDLE ahead of any transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else if (clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = handshake_s ? CHECK : IDLE;
            CHECK:   state_s = reject_s ? IDLE : SCAN;
            SCAN:    state_s = last_line_s ? RESULT : SCAN;
            RESULT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: only an idle, unfinished game accepts moves.
    always_comb begin
        move_ready = 1'b0;
        if ((state_r == IDLE) && !over_r) begin
            move_ready = 1'b1;
        end else begin
            move_ready = 1'b0;
        end
    end

    // Game datapath: latch move, write the board, accumulate line hits, publish the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_r          <= '0;
            mover_r        <= 1'b0;
            board_r        <= '0;
            turn_r         <= 1'b0;
            count_r        <= '0;
            over_r         <= 1'b0;
            winner_r       <= 2'b00;
            result_valid_r <= 1'b0;
            result_code_r  <= 2'b00;
            line_r         <= '0;
            hit_r          <= 1'b0;
        end else if (clear) begin
            pos_r          <= '0;
            mover_r        <= 1'b0;
            board_r        <= '0;
            turn_r         <= 1'b0;
            count_r        <= '0;
            over_r         <= 1'b0;
            winner_r       <= 2'b00;
            result_valid_r <= 1'b0;
            result_code_r  <= 2'b00;
            line_r         <= '0;
            hit_r          <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        pos_r   <= position;
                        mover_r <= player_id;
                    end
                end
                CHECK: begin
                    line_r <= '0;
                    hit_r  <= 1'b0;
                    if (reject_s) begin
                        result_valid_r <= 1'b1;
                        result_code_r  <= code_s;
                    end else begin
                        board_r[2*pos_idx_s +: 2] <= mover_code_s;
                        count_r <= count_r + CNT_W'(1);
                        turn_r  <= ~turn_r;
                    end
                end
                SCAN: begin
                    hit_r  <= hit_r | line_hit_s;
                    line_r <= line_r + LINE_W'(1);
                    // Result is registered here so the pulse lines up with the RESULT state.
                    if (last_line_s) begin
                        result_valid_r <= 1'b1;
                        result_code_r  <= 2'b00;
                        if (hit_r || line_hit_s) begin
                            over_r   <= 1'b1;
                            winner_r <= mover_code_s;
                        end else if (count_r == CNT_W'(CELLS)) begin
                            over_r   <= 1'b1;
                            winner_r <= 2'b11;
                        end
                    end
                end
                RESULT: begin
                    line_r <= '0;
                end
                default: begin
                    line_r <= '0;
                end
            endcase
        end
    end

    assign result_valid = result_valid_r;
    assign result_code  = result_code_r;
    assign turn         = turn_r;
    assign game_over    = over_r;
    assign winner       = winner_r;
    assign board_flat   = board_r;

endmodule
